// File: rtl/axis_pkg.sv
// Shared types and constants for the AXI4-Stream protocol checker: stream
// field widths, rule bit indices and the all-rules enable mask.
package axis_pkg;

    typedef struct packed {
        int unsigned DATA_W;
        int unsigned ID_W;
        int unsigned DEST_W;
        int unsigned USER_W;
    } axis_params_t;

    localparam axis_params_t AXIS_PARAMETERS_DEFAULT = '{
        DATA_W: 32,
        ID_W:   4,
        DEST_W: 4,
        USER_W: 1
    };

    localparam int ERR_WIDTH = 12;

    typedef enum logic [3:0] {
        RULE_VALID_DROP      = 4'd0,
        RULE_DATA_CHG        = 4'd1,
        RULE_STRB_CHG        = 4'd2,
        RULE_KEEP_CHG        = 4'd3,
        RULE_LAST_CHG        = 4'd4,
        RULE_ID_CHG          = 4'd5,
        RULE_DEST_CHG        = 4'd6,
        RULE_USER_CHG        = 4'd7,
        RULE_VALID_AFTER_RST = 4'd8,
        RULE_DATA_X          = 4'd9,
        RULE_STALL_TIMEOUT   = 4'd10,
        RULE_PKT_TOO_LONG    = 4'd11
    } axis_chk_rule_e;

    localparam logic [ERR_WIDTH-1:0] CHECK_ALL = '1;

endpackage

// File: rtl/axis_if.sv
// AXI4-Stream bundle with master, slave and passive monitor views.
interface axis_if #(
    parameter axis_pkg::axis_params_t AXIS_PARAMETERS = axis_pkg::AXIS_PARAMETERS_DEFAULT
);
    localparam int DATA_W = int'(AXIS_PARAMETERS.DATA_W);
    localparam int STRB_W = (DATA_W + 7) / 8;
    localparam int ID_W   = int'(AXIS_PARAMETERS.ID_W);
    localparam int DEST_W = int'(AXIS_PARAMETERS.DEST_W);
    localparam int USER_W = int'(AXIS_PARAMETERS.USER_W);

    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [STRB_W-1:0] tstrb;
    logic [STRB_W-1:0] tkeep;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [DEST_W-1:0] tdest;
    logic [USER_W-1:0] tuser;

    modport mst (output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, input tready);
    modport slv (input tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, output tready);
    modport mon (input tvalid, tready, tdata, tstrb, tkeep, tlast, tid, tdest, tuser);

endinterface

// File: rtl/axis_sat_counter.sv
// Up-counter that sticks at all ones; a clear restarts it, counting the
// increment of the same cycle.
module axis_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] value_o
);

    logic [WIDTH-1:0] value_q, value_d;

    // NOTE: the next state defaults to the current value before any branch so
    // this always_comb can never infer a latch.
    always_comb begin
        value_d = value_q;
        if (clr_i) begin
            value_d = inc_i ? WIDTH'(1) : '0;
        end else if (inc_i && (value_q != '1)) begin
            value_d = value_q + WIDTH'(1);
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // values that were present before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/axis_protocol_checker.sv
// Passive AXI4-Stream protocol checker: flags handshake-stability, reset,
// stall and packet-length violations and keeps saturating beat/packet counts.
module axis_protocol_checker
    import axis_pkg::*;
#(
    parameter axis_params_t          AXIS_PARAMETERS  = AXIS_PARAMETERS_DEFAULT,
    parameter logic [ERR_WIDTH-1:0]  CHECK_ENABLE     = CHECK_ALL,
    parameter int unsigned           MAX_STALL_CYCLES = 1024,
    parameter int unsigned           MAX_PACKET_BEATS = 4096,
    parameter int                    CNT_WIDTH        = 32
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    axis_if.mon                  mon,
    input  logic                 clear_i,
    output logic [ERR_WIDTH-1:0] err_sticky_o,
    output logic [ERR_WIDTH-1:0] err_pulse_o,
    output logic                 error_o,
    output logic [CNT_WIDTH-1:0] beat_cnt_o,
    output logic [CNT_WIDTH-1:0] pkt_cnt_o
);

    localparam int DATA_W  = int'(AXIS_PARAMETERS.DATA_W);
    localparam int STRB_W  = (DATA_W + 7) / 8;
    localparam int ID_W    = int'(AXIS_PARAMETERS.ID_W);
    localparam int DEST_W  = int'(AXIS_PARAMETERS.DEST_W);
    localparam int USER_W  = int'(AXIS_PARAMETERS.USER_W);
    // Tracker widths leave headroom above the threshold so saturation never re-fires.
    localparam int STALL_W = (MAX_STALL_CYCLES > 0) ? $clog2(MAX_STALL_CYCLES + 1) : 1;
    localparam int PKT_W   = (MAX_PACKET_BEATS > 0) ? $clog2(MAX_PACKET_BEATS + 2) : 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic [STRB_W-1:0] keep;
        logic              last;
        logic [ID_W-1:0]   id;
        logic [DEST_W-1:0] dest;
        logic [USER_W-1:0] user;
    } beat_t;

    beat_t                cur_beat, snap_q;
    logic                 pend_q, pend_d;
    logic                 first_q;
    logic                 accepted, stalled, data_x;
    logic [STALL_W-1:0]   stall_cnt;
    logic [PKT_W-1:0]     pkt_beat_cnt;
    logic [ERR_WIDTH-1:0] raw_d, viol_d;
    logic [ERR_WIDTH-1:0] err_sticky_q, err_sticky_d;
    logic [ERR_WIDTH-1:0] err_pulse_q;

    assign cur_beat = '{
        data: mon.tdata,
        strb: mon.tstrb,
        keep: mon.tkeep,
        last: mon.tlast,
        id:   mon.tid,
        dest: mon.tdest,
        user: mon.tuser
    };

    assign accepted = mon.tvalid && mon.tready;
    assign stalled  = mon.tvalid && !mon.tready;
    assign pend_d   = stalled;

`ifdef SYNTHESIS
    assign data_x = 1'b0;
`else
    assign data_x = mon.tvalid && $isunknown(mon.tdata);
`endif

    axis_sat_counter #(.WIDTH(CNT_WIDTH)) u_beat_cnt (
        .clk(ACLK), .rst_n(ARESETn), .inc_i(accepted), .clr_i(clear_i), .value_o(beat_cnt_o)
    );

    axis_sat_counter #(.WIDTH(CNT_WIDTH)) u_pkt_cnt (
        .clk(ACLK), .rst_n(ARESETn), .inc_i(accepted && mon.tlast), .clr_i(clear_i),
        .value_o(pkt_cnt_o)
    );

    axis_sat_counter #(.WIDTH(STALL_W)) u_stall_cnt (
        .clk(ACLK), .rst_n(ARESETn), .inc_i(stalled), .clr_i(!stalled), .value_o(stall_cnt)
    );

    axis_sat_counter #(.WIDTH(PKT_W)) u_pkt_beat_cnt (
        .clk(ACLK), .rst_n(ARESETn), .inc_i(accepted && !mon.tlast),
        .clr_i(accepted && mon.tlast), .value_o(pkt_beat_cnt)
    );

    // Field changes only matter while TVALID stays up; a drop is its own rule.
    always_comb begin
        raw_d = '0;
        if (pend_q) begin
            raw_d[RULE_VALID_DROP] = !mon.tvalid;
            raw_d[RULE_DATA_CHG]   = mon.tvalid && (cur_beat.data != snap_q.data);
            raw_d[RULE_STRB_CHG]   = mon.tvalid && (cur_beat.strb != snap_q.strb);
            raw_d[RULE_KEEP_CHG]   = mon.tvalid && (cur_beat.keep != snap_q.keep);
            raw_d[RULE_LAST_CHG]   = mon.tvalid && (cur_beat.last != snap_q.last);
            raw_d[RULE_ID_CHG]     = mon.tvalid && (cur_beat.id   != snap_q.id);
            raw_d[RULE_DEST_CHG]   = mon.tvalid && (cur_beat.dest != snap_q.dest);
            raw_d[RULE_USER_CHG]   = mon.tvalid && (cur_beat.user != snap_q.user);
        end
        raw_d[RULE_VALID_AFTER_RST] = first_q && mon.tvalid;
        raw_d[RULE_DATA_X]          = data_x;
        if (MAX_STALL_CYCLES != 0) begin
            raw_d[RULE_STALL_TIMEOUT] = stalled &&
                (stall_cnt == STALL_W'(MAX_STALL_CYCLES - 1));
        end
        if (MAX_PACKET_BEATS != 0) begin
            raw_d[RULE_PKT_TOO_LONG] = accepted && !mon.tlast &&
                (pkt_beat_cnt == PKT_W'(MAX_PACKET_BEATS));
        end
    end

    assign viol_d       = raw_d & CHECK_ENABLE;
    // A violation in the clearing cycle still lands in the sticky flags.
    assign err_sticky_d = (clear_i ? '0 : err_sticky_q) | viol_d;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            pend_q       <= 1'b0;
            snap_q       <= '0;
            first_q      <= 1'b1;
            err_sticky_q <= '0;
            err_pulse_q  <= '0;
        end else begin
            pend_q       <= pend_d;
            first_q      <= 1'b0;
            err_sticky_q <= err_sticky_d;
            err_pulse_q  <= viol_d;
            if (pend_d) begin
                snap_q <= cur_beat;
            end
        end
    end

    assign err_sticky_o = err_sticky_q;
    assign err_pulse_o  = err_pulse_q;
    assign error_o      = |err_sticky_q;

endmodule

// File: tb/tb_axis_protocol_checker.sv
// Directed bench: two checkers tap one stream, one with short stall/packet
// limits, the other with DATA_CHG masked and 4-bit counters.
module tb_axis_protocol_checker;
    import axis_pkg::*;

    logic aclk;
    logic rst_n;
    logic clear;

    logic [ERR_WIDTH-1:0] a_sticky, a_pulse, b_sticky, b_pulse;
    logic                 a_err, b_err;
    logic [31:0]          a_beat, a_pkt;
    logic [3:0]           b_beat, b_pkt;

    int checks = 0;
    int errors = 0;

    axis_if bus ();

    axis_protocol_checker #(
        .MAX_STALL_CYCLES(4),
        .MAX_PACKET_BEATS(8)
    ) u_a (
        .ACLK(aclk), .ARESETn(rst_n), .mon(bus), .clear_i(clear),
        .err_sticky_o(a_sticky), .err_pulse_o(a_pulse), .error_o(a_err),
        .beat_cnt_o(a_beat), .pkt_cnt_o(a_pkt)
    );

    axis_protocol_checker #(
        .CHECK_ENABLE(CHECK_ALL & ~12'h002),
        .CNT_WIDTH(4)
    ) u_b (
        .ACLK(aclk), .ARESETn(rst_n), .mon(bus), .clear_i(clear),
        .err_sticky_o(b_sticky), .err_pulse_o(b_pulse), .error_o(b_err),
        .beat_cnt_o(b_beat), .pkt_cnt_o(b_pkt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle();
        bus.tvalid = 1'b0; bus.tready = 1'b0; bus.tdata = '0; bus.tlast = 1'b0;
        bus.tstrb = 4'hF; bus.tkeep = 4'hF; bus.tid = '0; bus.tdest = '0; bus.tuser = '0;
    endtask

    task automatic drive(input logic v, input logic r, input logic [31:0] d, input logic l);
        bus.tvalid = v; bus.tready = r; bus.tdata = d; bus.tlast = l;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; clear = 1'b0; idle();
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; idle();
        tick(); tick();
        checks++; if (a_sticky !== '0) begin errors++; $display("FAIL rst_a_sticky got=%h exp=000", a_sticky); end
        checks++; if (a_pulse !== '0) begin errors++; $display("FAIL rst_a_pulse got=%h exp=000", a_pulse); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL rst_a_err got=%b exp=0", a_err); end
        checks++; if (a_beat !== 32'd0 || a_pkt !== 32'd0) begin errors++; $display("FAIL rst_a_cnt got=%0d/%0d exp=0/0", a_beat, a_pkt); end
        checks++; if (b_sticky !== '0 || b_beat !== 4'd0 || b_pkt !== 4'd0) begin errors++; $display("FAIL rst_b got=%h/%0d/%0d exp=000/0/0", b_sticky, b_beat, b_pkt); end
        rst_n = 1'b1;
        tick();
        checks++; if (a_sticky !== '0 || b_sticky !== '0) begin errors++; $display("FAIL rst_idle_release got=%h/%h exp=000/000", a_sticky, b_sticky); end
    endtask

    task automatic test_data_chg();
        do_reset();
        drive(1'b1, 1'b0, 32'hA5, 1'b0); tick();
        checks++; if (a_pulse !== '0) begin errors++; $display("FAIL dchg_first got=%h exp=000", a_pulse); end
        drive(1'b1, 1'b0, 32'h5A, 1'b0); tick();
        checks++; if (a_pulse !== 12'h002) begin errors++; $display("FAIL dchg_pulse got=%h exp=002", a_pulse); end
        checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL dchg_err got=%b exp=1", a_err); end
        checks++; if (b_pulse !== '0) begin errors++; $display("FAIL dchg_masked_pulse got=%h exp=000", b_pulse); end
        drive(1'b1, 1'b1, 32'h5A, 1'b0); tick();
        checks++; if (a_pulse !== '0) begin errors++; $display("FAIL dchg_one_cycle got=%h exp=000", a_pulse); end
        checks++; if (a_sticky !== 12'h002 || a_err !== 1'b1) begin errors++; $display("FAIL dchg_sticky got=%h/%b exp=002/1", a_sticky, a_err); end
        checks++; if (b_sticky !== '0 || b_err !== 1'b0) begin errors++; $display("FAIL dchg_masked_sticky got=%h/%b exp=000/0", b_sticky, b_err); end
        idle(); tick();
    endtask

    task automatic test_counts();
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 1'b1, 32'(i * 17), (i == 5) || (i == 10));
            tick();
        end
        idle(); tick();
        checks++; if (a_beat !== 32'd10) begin errors++; $display("FAIL cnt_beats got=%0d exp=10", a_beat); end
        checks++; if (a_pkt !== 32'd2) begin errors++; $display("FAIL cnt_pkts got=%0d exp=2", a_pkt); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL cnt_err got=%b exp=0", a_err); end
        checks++; if (b_beat !== 4'd10 || b_pkt !== 4'd2) begin errors++; $display("FAIL cnt_b got=%0d/%0d exp=10/2", b_beat, b_pkt); end
    endtask

    task automatic test_stall();
        logic [ERR_WIDTH-1:0] exp;
        do_reset();
        drive(1'b1, 1'b0, 32'hC3, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp = (k == 4) ? 12'h400 : 12'h000;
            checks++; if (a_pulse !== exp) begin errors++; $display("FAIL stall_cycle%0d got=%h exp=%h", k, a_pulse, exp); end
        end
        drive(1'b1, 1'b1, 32'hC3, 1'b0); tick();
        checks++; if (a_pulse !== '0 || a_sticky !== 12'h400) begin errors++; $display("FAIL stall_accept got=%h/%h exp=000/400", a_pulse, a_sticky); end
        checks++; if (b_sticky !== '0) begin errors++; $display("FAIL stall_b got=%h exp=000", b_sticky); end
        drive(1'b1, 1'b0, 32'hC4, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp = (k == 4) ? 12'h400 : 12'h000;
            checks++; if (a_pulse !== exp) begin errors++; $display("FAIL stall_rearm%0d got=%h exp=%h", k, a_pulse, exp); end
        end
        drive(1'b1, 1'b1, 32'hC4, 1'b0); tick();
        idle(); tick();
    endtask

    task automatic test_valid_after_rst();
        rst_n = 1'b0; clear = 1'b0; idle();
        drive(1'b1, 1'b0, 32'h77, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks++; if (a_pulse !== 12'h100 || a_sticky !== 12'h100) begin errors++; $display("FAIL var_a got=%h/%h exp=100/100", a_pulse, a_sticky); end
        checks++; if (b_sticky !== 12'h100 || b_err !== 1'b1) begin errors++; $display("FAIL var_b got=%h/%b exp=100/1", b_sticky, b_err); end
        clear = 1'b1;
        drive(1'b1, 1'b1, 32'h77, 1'b0); tick();
        clear = 1'b0;
        checks++; if (a_sticky !== '0 || a_pulse !== '0 || a_err !== 1'b0) begin errors++; $display("FAIL var_clear got=%h/%h/%b exp=000/000/0", a_sticky, a_pulse, a_err); end
        checks++; if (a_beat !== 32'd1) begin errors++; $display("FAIL var_clear_count got=%0d exp=1", a_beat); end
        idle(); tick();
    endtask

    task automatic test_clear_vs_violation();
        do_reset();
        drive(1'b1, 1'b0, 32'h11, 1'b0); tick();
        drive(1'b1, 1'b0, 32'h22, 1'b0); clear = 1'b1; tick();
        clear = 1'b0;
        checks++; if (a_sticky !== 12'h002 || a_pulse !== 12'h002) begin errors++; $display("FAIL clrviol got=%h/%h exp=002/002", a_sticky, a_pulse); end
        drive(1'b1, 1'b1, 32'h22, 1'b0); tick();
        idle(); tick();
        checks++; if (a_sticky !== 12'h002) begin errors++; $display("FAIL clrviol_hold got=%h exp=002", a_sticky); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        drive(1'b1, 1'b0, 32'h33, 1'b0); tick();
        bus.tdata = 32'h44; bus.tstrb = 4'h3; bus.tkeep = 4'h1; bus.tlast = 1'b1;
        bus.tid = 4'h5; bus.tdest = 4'h6; bus.tuser = 1'b1;
        tick();
        checks++; if (a_pulse !== 12'h0FE) begin errors++; $display("FAIL multi_a got=%h exp=0fe", a_pulse); end
        checks++; if (b_pulse !== 12'h0FC) begin errors++; $display("FAIL multi_b got=%h exp=0fc", b_pulse); end
        bus.tready = 1'b1; tick();
        checks++; if (a_pulse !== '0) begin errors++; $display("FAIL multi_accept got=%h exp=000", a_pulse); end
        idle(); tick();
        checks++; if (a_sticky !== 12'h0FE) begin errors++; $display("FAIL multi_sticky got=%h exp=0fe", a_sticky); end
    endtask

    task automatic test_pkt_too_long();
        logic [ERR_WIDTH-1:0] exp;
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 1'b1, 32'(i), 1'b0); tick();
            exp = (i == 9) ? 12'h800 : 12'h000;
            checks++; if (a_pulse !== exp) begin errors++; $display("FAIL pktlen_beat%0d got=%h exp=%h", i, a_pulse, exp); end
        end
        drive(1'b1, 1'b1, 32'h0B, 1'b1); tick();
        checks++; if (a_pulse !== '0) begin errors++; $display("FAIL pktlen_last got=%h exp=000", a_pulse); end
        idle(); tick();
        checks++; if (a_pkt !== 32'd1 || a_sticky !== 12'h800) begin errors++; $display("FAIL pktlen_end got=%0d/%h exp=1/800", a_pkt, a_sticky); end
        checks++; if (b_sticky !== '0) begin errors++; $display("FAIL pktlen_b got=%h exp=000", b_sticky); end
    endtask

    task automatic test_saturation_async_reset();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 32'(i), 1'b1); tick();
        end
        idle(); tick();
        checks++; if (b_beat !== 4'hF || b_pkt !== 4'hF) begin errors++; $display("FAIL sat_b got=%0d/%0d exp=15/15", b_beat, b_pkt); end
        checks++; if (a_beat !== 32'd20 || a_pkt !== 32'd20) begin errors++; $display("FAIL sat_a got=%0d/%0d exp=20/20", a_beat, a_pkt); end
        drive(1'b1, 1'b1, 32'h01, 1'b0); tick();
        drive(1'b1, 1'b0, 32'h02, 1'b0); tick();
        idle(); tick();
        checks++; if (a_pulse !== 12'h001 || a_err !== 1'b1) begin errors++; $display("FAIL vdrop got=%h/%b exp=001/1", a_pulse, a_err); end
        rst_n = 1'b0;
        #2;
        checks++; if (a_sticky !== '0 || a_pulse !== '0 || a_err !== 1'b0) begin errors++; $display("FAIL arst_a_err got=%h/%h/%b exp=000/000/0", a_sticky, a_pulse, a_err); end
        checks++; if (a_beat !== 32'd0 || a_pkt !== 32'd0) begin errors++; $display("FAIL arst_a_cnt got=%0d/%0d exp=0/0", a_beat, a_pkt); end
        checks++; if (b_sticky !== '0 || b_pulse !== '0 || b_err !== 1'b0 || b_beat !== 4'd0 || b_pkt !== 4'd0) begin errors++; $display("FAIL arst_b got=%h/%h/%b/%0d/%0d exp=000/000/0/0/0", b_sticky, b_pulse, b_err, b_beat, b_pkt); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        idle();
        test_reset();
        test_data_chg();
        test_counts();
        test_stall();
        test_valid_after_rst();
        test_clear_vs_violation();
        test_simultaneous();
        test_pkt_too_long();
        test_saturation_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_protocol_checker.md
AXIS_PROTOCOL_CHECKER -- requirements
Module: axis_protocol_checker

Interface
REQ-001 Parameter AXIS_PARAMETERS, default axis_pkg::AXIS_PARAMETERS_DEFAULT, stream field widths.
REQ-002 Parameter CHECK_ENABLE, default all ones (ERR_WIDTH bits), per-rule enable mask; a disabled rule never sets its error bit.
REQ-003 Parameter MAX_STALL_CYCLES, default 1024; 0 disables the stall rule.
REQ-004 Parameter MAX_PACKET_BEATS, default 4096; 0 disables the packet-length rule.
REQ-005 Parameter CNT_WIDTH, default 32, width of statistics counters.
REQ-006 Clocking: one clock ACLK; ARESETn is asynchronous, active-low.
REQ-007 ACLK  input  1  sole clock.
REQ-008 ARESETn  input  1  asynchronous active-low reset.
REQ-009 mon  axis_if.mon  -  passive tap; mon modport added to axis_if with every signal an input; checker drives nothing on the stream.
REQ-010 clear_i  input  1  synchronous clear of sticky errors and counters.
REQ-011 err_sticky_o  output  ERR_WIDTH  per-rule sticky violation flags.
REQ-012 err_pulse_o  output  ERR_WIDTH  per-rule flag, high one cycle per detected violation.
REQ-013 error_o  output  1  OR of err_sticky_o.
REQ-014 beat_cnt_o  output  CNT_WIDTH  accepted beats (TVALID&&TREADY), saturating.
REQ-015 pkt_cnt_o  output  CNT_WIDTH  accepted TLAST beats, saturating.

Function
REQ-016 Rules, bit order: 0 VALID_DROP, 1 DATA_CHG, 2 STRB_CHG, 3 KEEP_CHG, 4 LAST_CHG, 5 ID_CHG, 6 DEST_CHG, 7 USER_CHG, 8 VALID_AFTER_RST, 9 DATA_X, 10 STALL_TIMEOUT, 11 PKT_TOO_LONG.
REQ-017 Pending: registered flag pend_q = TVALID&&!TREADY at previous edge; field snapshot registered simultaneously.
REQ-018 When pend_q: TVALID low -> VALID_DROP; each field differing from snapshot -> its *_CHG bit; comparison at current cycle, pulse registered, one cycle latency.
REQ-019 VALID_AFTER_RST: TVALID high at first ACLK edge after ARESETn release.
REQ-020 DATA_X: TVALID high and TDATA contains X/Z; evaluated in simulation only, tied 0 under synthesis.
REQ-021 Stall counter increments each cycle pend is true, clears on accepted beat or TVALID low; reaching MAX_STALL_CYCLES sets STALL_TIMEOUT once per stall episode.
REQ-022 Beat-in-packet counter increments per accepted beat, clears after accepted TLAST; accepted beat number MAX_PACKET_BEATS+1 without TLAST sets PKT_TOO_LONG once per packet.
REQ-023 err_pulse_o asserted cycle after violation sample; err_sticky_o set same cycle; sticky bits only cleared by reset or clear_i.
REQ-024 Counters saturate at all ones; never wrap.
REQ-025 clear_i and a violation in same cycle: violation wins (sticky bit set, pulse emitted); counters clear then count that cycle's beat.
REQ-026 Simultaneous violations of several rules all flagged in the same cycle.
REQ-027 Checks suppressed while ARESETn low.

Reset
REQ-028 ARESETn low: err_sticky_o, err_pulse_o, error_o, counters, pend_q, stall and beat-in-packet counters all 0; first-cycle flag set to 1, cleared at first edge after release.

Structure
REQ-029 axis_pkg holds ERR_WIDTH (12), enum axis_chk_rule_e of bit indices, CHECK_ALL mask constant.
REQ-030 Sub-module axis_sat_counter (parameter WIDTH; inc, clr, value) used for beat, packet, stall and beat-in-packet counters.
REQ-031 Pure observer; synthesizable except REQ-020.

Verification
REQ-032 TVALID=1, TREADY=0, TDATA 0xA5 then 0x5A next cycle -> err_pulse_o[1]=1 one cycle, error_o=1 sticky.
REQ-033 10 beats, TLAST on 5th and 10th, TREADY=1 -> beat_cnt_o=10, pkt_cnt_o=2, error_o=0.
REQ-034 MAX_STALL_CYCLES=4, TVALID held, TREADY low 6 cycles -> single STALL_TIMEOUT pulse after 4th stalled cycle.
REQ-035 TVALID=1 at first edge after ARESETn rise -> bit 8 set; clear_i pulse -> err_sticky_o=0.
REQ-036 CHECK_ENABLE bit 1 cleared, repeat REQ-032 -> err_sticky_o=0.
REQ-037 CNT_WIDTH=4, 20 beats -> beat_cnt_o=15; ARESETn asserted mid-packet -> all outputs 0 asynchronously.
